// File: rtl/boot_load_ctrl.sv
// Boot loader: packs UART bytes into little-endian words, writes them to
// instruction memory and holds the core in reset until the load finishes.
//
// state | meaning
// IDLE  | after reset, decide between loading and running
// RUN   | core released, waiting for a rising edge on prog_i
// LOAD  | core held, assembling and writing words
// DONE  | core held for RST_HOLD cycles before release
module boot_load_ctrl #(
    parameter int          ADDR_W      = 14,
    parameter logic [31:0] END_WORD    = 32'h0000_0FFF,
    parameter int          TIMEOUT_CYC = 1_000_000,
    parameter int          RST_HOLD    = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              prog_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [31:0]       wdata_o,
    output logic              core_rst_no,
    output logic              busy_o,
    output logic [ADDR_W:0]   words_o,
    output logic              ovf_o,
    output logic              to_err_o
);
    localparam int TMR_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD - 1);
    localparam logic [ADDR_W:0]   DEPTH     = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, LOAD, DONE} state_t;

    state_t             state;
    logic               prog_q;
    logic [23:0]        byte_buf;
    logic [1:0]         bcnt;
    logic [TMR_W-1:0]   tmr;
    logic [HOLD_W-1:0]  hold;
    logic [31:0]        word;
    logic               start_load;

    assign word       = {byte_i, byte_buf};
    assign busy_o     = (state == LOAD) || (state == DONE);
    assign start_load = ((state == IDLE) && prog_i) ||
                        ((state == RUN) && prog_i && !prog_q);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= IDLE;
            prog_q      <= 1'b0;
            byte_buf    <= '0;
            bcnt        <= '0;
            tmr         <= '0;
            hold        <= '0;
            we_o        <= 1'b0;
            addr_o      <= '0;
            wdata_o     <= '0;
            core_rst_no <= 1'b0;
            words_o     <= '0;
            ovf_o       <= 1'b0;
            to_err_o    <= 1'b0;
        end else begin
            prog_q <= prog_i;
            we_o   <= 1'b0;
            if (start_load) begin
                state       <= LOAD;
                core_rst_no <= 1'b0;
                words_o     <= '0;
                bcnt        <= '0;
                tmr         <= TMR_LOAD;
                ovf_o       <= 1'b0;
                to_err_o    <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= RUN;
                    RUN:  core_rst_no <= 1'b1;
                    LOAD: begin
                        if (byte_valid_i) begin
                            tmr <= TMR_LOAD;
                            if (bcnt == 2'd3) begin
                                bcnt <= '0;
                                if (word == END_WORD) begin
                                    state <= DONE;
                                    hold  <= HOLD_LOAD;
                                end else if (words_o < DEPTH) begin
                                    we_o    <= 1'b1;
                                    addr_o  <= words_o[ADDR_W-1:0];
                                    wdata_o <= word;
                                    words_o <= words_o + 1'b1;
                                end else begin
                                    ovf_o <= 1'b1;
                                end
                            end else begin
                                byte_buf[{bcnt, 3'b000} +: 8] <= byte_i;
                                bcnt <= bcnt + 1'b1;
                            end
                        end else if (tmr == '0) begin
                            // idle too long: any partially assembled word is dropped
                            state <= DONE;
                            hold  <= HOLD_LOAD;
                            bcnt  <= '0;
                            if (bcnt != 2'd0) to_err_o <= 1'b1;
                        end else begin
                            tmr <= tmr - 1'b1;
                        end
                    end
                    DONE: begin
                        if (hold == '0) state <= RUN;
                        else            hold  <= hold - 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_boot_load_ctrl.sv
// Randomized bench for boot_load_ctrl: a wide (ADDR_W=14) and a tiny (ADDR_W=2)
// instance see identical stimulus and are checked against a word-list model.
module tb_boot_load_ctrl;
    localparam int          T    = 100;
    localparam logic [31:0] ENDW = 32'h0000_0FFF;

    logic clk = 1'b0, rst_n = 1'b0, prog = 1'b0, bv = 1'b0;
    logic [7:0] bt = 8'h00;

    logic        a_we, a_rst, a_busy, a_ovf, a_terr;
    logic [13:0] a_addr;
    logic [31:0] a_wdata;
    logic [14:0] a_words;
    logic        b_we, b_rst, b_busy, b_ovf, b_terr;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata;
    logic [2:0]  b_words;

    boot_load_ctrl #(.ADDR_W(14), .END_WORD(ENDW), .TIMEOUT_CYC(T), .RST_HOLD(16)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .prog_i(prog), .byte_valid_i(bv), .byte_i(bt),
        .we_o(a_we), .addr_o(a_addr), .wdata_o(a_wdata), .core_rst_no(a_rst),
        .busy_o(a_busy), .words_o(a_words), .ovf_o(a_ovf), .to_err_o(a_terr));

    boot_load_ctrl #(.ADDR_W(2), .END_WORD(ENDW), .TIMEOUT_CYC(T), .RST_HOLD(16)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .prog_i(prog), .byte_valid_i(bv), .byte_i(bt),
        .we_o(b_we), .addr_o(b_addr), .wdata_o(b_wdata), .core_rst_no(b_rst),
        .busy_o(b_busy), .words_o(b_words), .ovf_o(b_ovf), .to_err_o(b_terr));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;
    logic [47:0] qa[$], qb[$], ea[$], eb[$];
    logic [7:0]  stim[$];
    int   ewa, ewb, e_last, dt;
    logic eova, eovb, eterr;

    always @(negedge clk) begin
        if (a_we) qa.push_back({16'(a_addr), a_wdata});
        if (b_we) qb.push_back({16'(b_addr), b_wdata});
    end

    // Reference: split the byte stream into LE words, stop at the terminator,
    // keep the first 'depth' words, flag the rest as overflow.
    task automatic model();
        logic [31:0] w;
        int nw;
        bit term;
        nw = stim.size() / 4;
        term = 1'b0;
        ea.delete(); eb.delete();
        ewa = 0; ewb = 0; eova = 1'b0; eovb = 1'b0;
        for (int i = 0; i < nw && !term; i++) begin
            w = {stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]};
            if (w == ENDW) term = 1'b1;
            else begin
                if (ewa < 2**14) begin ea.push_back({16'(ewa), w}); ewa++; end else eova = 1'b1;
                if (ewb < 4)     begin eb.push_back({16'(ewb), w}); ewb++; end else eovb = 1'b1;
            end
        end
        eterr = !term && (stim.size() % 4 != 0);
    endtask

    function automatic bit q_eq(input logic [47:0] x[$], input logic [47:0] y[$]);
        if (x.size() != y.size()) return 1'b0;
        foreach (x[i]) if (x[i] !== y[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) stim.push_back(w[8*i +: 8]);
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        while (w == ENDW) w = $urandom;
        return w;
    endfunction

    task automatic start_load();
        qa.delete(); qb.delete();
        prog = 1'b1;
        @(negedge clk);
        prog = 1'b0;
    endtask

    task automatic send_stim(input int gmin, input int gmax);
        int g;
        foreach (stim[i]) begin
            bv = 1'b1; bt = stim[i];
            @(negedge clk);
            bv = 1'b0;
            e_last = cyc;
            g = int'($urandom_range(gmax, gmin));
            repeat (g) @(negedge clk);
        end
    endtask

    task automatic wait_run(input string name);
        int k;
        k = 0;
        while (!(a_rst && b_rst) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (!(a_rst && b_rst)) begin
            bad++;
            $display("FAIL %s_release: core_rst_no=%b/%b after %0d cycles, required 1", name, a_rst, b_rst, k);
        end
        dt = cyc - e_last;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; prog = 1'b0; bv = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({a_we, a_addr, a_wdata, a_rst, a_busy, a_words, a_ovf, a_terr} !== '0) begin
            bad++; $display("FAIL reset_a: outputs=%h, required 0",
                {a_we, a_addr, a_wdata, a_rst, a_busy, a_words, a_ovf, a_terr});
        end
        total++;
        if ({b_we, b_addr, b_wdata, b_rst, b_busy, b_words, b_ovf, b_terr} !== '0) begin
            bad++; $display("FAIL reset_b: outputs=%h, required 0",
                {b_we, b_addr, b_wdata, b_rst, b_busy, b_words, b_ovf, b_terr});
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (a_rst !== 1'b0) begin bad++; $display("FAIL reset_edge1: core_rst_no=%b, required 0", a_rst); end
        @(negedge clk);
        total++;
        if (a_rst !== 1'b1 || b_rst !== 1'b1) begin
            bad++; $display("FAIL reset_edge2: core_rst_no=%b/%b, required 1", a_rst, b_rst);
        end
        total++;
        if (qa.size() != 0) begin bad++; $display("FAIL reset_nowrite: writes=%0d, required 0", qa.size()); end
    endtask

    task automatic test_basic();
        logic [7:0] seq[12];
        seq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h0F, 8'h00, 8'h00};
        stim.delete();
        foreach (seq[i]) stim.push_back(seq[i]);
        model();
        start_load();
        send_stim(0, 0);
        wait_run("basic");
        total++;
        if (!q_eq(qa, ea)) begin bad++; $display("FAIL basic_writes: got %0d writes, required %0d", qa.size(), ea.size()); end
        total++;
        if (dt != 17) begin bad++; $display("FAIL basic_hold: release after %0d cycles, required 17", dt); end
        total++;
        if (a_words !== 15'(ewa)) begin bad++; $display("FAIL basic_words: words=%0d, required %0d", a_words, ewa); end
    endtask

    task automatic test_back_to_back();
        int gaps[2];
        gaps = '{0, 3};
        foreach (gaps[g]) begin
            stim.delete();
            for (int i = 0; i < 3; i++) push_word(rand_word());
            push_word(ENDW);
            model();
            start_load();
            send_stim(gaps[g], gaps[g]);
            wait_run("b2b");
            total++;
            if (!q_eq(qa, ea)) begin bad++; $display("FAIL b2b_writes gap=%0d: got %0d writes, required %0d", gaps[g], qa.size(), ea.size()); end
            total++;
            if (!q_eq(qb, eb)) begin bad++; $display("FAIL b2b_writes_b gap=%0d: got %0d writes, required %0d", gaps[g], qb.size(), eb.size()); end
        end
    endtask

    task automatic test_random();
        int nw, mode;
        for (int it = 0; it < 8; it++) begin
            stim.delete();
            nw = int'($urandom_range(6, 0));
            for (int i = 0; i < nw; i++) push_word(rand_word());
            mode = int'($urandom_range(3, 0));
            if (mode == 0) push_word(ENDW);
            else for (int i = 1; i < mode; i++) stim.push_back(8'($urandom));
            model();
            start_load();
            send_stim(0, 3);
            wait_run("rand");
            total++;
            if (!q_eq(qa, ea)) begin bad++; $display("FAIL rand_writes_a it=%0d: got %0d writes, required %0d", it, qa.size(), ea.size()); end
            total++;
            if (!q_eq(qb, eb)) begin bad++; $display("FAIL rand_writes_b it=%0d: got %0d writes, required %0d", it, qb.size(), eb.size()); end
            total++;
            if (a_words !== 15'(ewa) || b_words !== 3'(ewb)) begin
                bad++; $display("FAIL rand_words it=%0d: words=%0d/%0d, required %0d/%0d", it, a_words, b_words, ewa, ewb);
            end
            total++;
            if (a_ovf !== eova || b_ovf !== eovb || a_terr !== eterr || b_terr !== eterr) begin
                bad++; $display("FAIL rand_flags it=%0d: ovf=%b/%b to_err=%b/%b, required %b/%b %b",
                    it, a_ovf, b_ovf, a_terr, b_terr, eova, eovb, eterr);
            end
        end
    endtask

    task automatic test_timeout();
        stim.delete();
        stim.push_back(8'($urandom));
        stim.push_back(8'($urandom));
        model();
        start_load();
        send_stim(0, 0);
        repeat (T / 2) @(negedge clk);
        total++;
        if (a_busy !== 1'b1 || a_terr !== 1'b0) begin
            bad++; $display("FAIL to_mid: busy=%b to_err=%b, required 1 0", a_busy, a_terr);
        end
        wait_run("timeout");
        total++;
        if (dt < T + 16 || dt > T + 18) begin bad++; $display("FAIL to_time: release after %0d cycles, required about %0d", dt, T + 17); end
        total++;
        if (a_terr !== eterr || b_terr !== eterr) begin bad++; $display("FAIL to_err: to_err=%b/%b, required %b", a_terr, b_terr, eterr); end
        total++;
        if (qa.size() != 0 || qb.size() != 0) begin bad++; $display("FAIL to_nowrite: writes=%0d/%0d, required 0", qa.size(), qb.size()); end
        total++;
        if (a_busy !== 1'b0) begin bad++; $display("FAIL to_busy: busy=%b, required 0", a_busy); end
    endtask

    task automatic test_overflow();
        stim.delete();
        for (int i = 0; i < 5; i++) push_word(rand_word());
        push_word(ENDW);
        model();
        start_load();
        send_stim(0, 2);
        wait_run("ovf");
        total++;
        if (!q_eq(qb, eb)) begin bad++; $display("FAIL ovf_writes_b: got %0d writes, required %0d", qb.size(), eb.size()); end
        total++;
        if (qb.size() == 4) begin
            foreach (qb[i]) if (qb[i][47:32] != 16'(i)) begin
                bad++; $display("FAIL ovf_addr: write %0d addr=%0d, required %0d", i, qb[i][47:32], i);
            end
        end else begin
            bad++; $display("FAIL ovf_count: writes=%0d, required 4", qb.size());
        end
        total++;
        if (b_words !== 3'd4 || b_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flags_b: words=%0d ovf=%b, required 4 1", b_words, b_ovf); end
        total++;
        if (!q_eq(qa, ea) || a_ovf !== 1'b0) begin bad++; $display("FAIL ovf_a: writes=%0d ovf=%b, required %0d 0", qa.size(), a_ovf, ea.size()); end
    endtask

    task automatic test_reset_mid();
        stim.delete();
        for (int i = 0; i < 3; i++) stim.push_back(8'($urandom));
        start_load();
        send_stim(0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({a_we, a_addr, a_wdata, a_rst, a_busy, a_words, a_ovf, a_terr} !== '0 || qa.size() != 0) begin
            bad++; $display("FAIL midrst_a: outputs=%h writes=%0d, required 0 0",
                {a_we, a_addr, a_wdata, a_rst, a_busy, a_words, a_ovf, a_terr}, qa.size());
        end
        total++;
        if ({b_we, b_addr, b_wdata, b_rst, b_busy, b_words, b_ovf, b_terr} !== '0) begin
            bad++; $display("FAIL midrst_b: outputs=%h, required 0",
                {b_we, b_addr, b_wdata, b_rst, b_busy, b_words, b_ovf, b_terr});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        stim.delete();
        push_word(rand_word());
        push_word(ENDW);
        model();
        start_load();
        send_stim(0, 1);
        wait_run("midrst");
        total++;
        if (!q_eq(qa, ea)) begin bad++; $display("FAIL midrst_reload: got %0d writes, required %0d at addr 0", qa.size(), ea.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_random();
        test_timeout();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
